// File: rtl/decode_stage_pipelined_pkg.sv
// Shared definitions for the decode stage: control-bundle bit positions,
// instruction field layout and the opcode/funct constants of the control unit.
package decode_stage_pipelined_pkg;

  localparam int unsigned INSTR_W = 32;

  // Control bundle bit positions; bits above CTRL_USES_RT are carried opaquely
  localparam int unsigned CTRL_REG_WRITE = 0;
  localparam int unsigned CTRL_MEM_READ  = 1;
  localparam int unsigned CTRL_BRANCH    = 2;
  localparam int unsigned CTRL_BRANCH_NE = 3;
  localparam int unsigned CTRL_LAMUX     = 4;
  localparam int unsigned CTRL_USES_RT   = 5;
  localparam int unsigned CTRL_KNOWN_W   = 6;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Instruction word split into R-type fields; I-type immediate is {rd, shamt, funct}
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instrFields_t;

  // Reassemble the 16-bit immediate from the R-type view of the word
  function automatic logic [15:0] imm16(input instrFields_t iw);
    return {iw.rd, iw.shamt, iw.funct};
  endfunction

endpackage

// File: rtl/decode_stage_pipelined_if.sv
// Bus between the IF/ID register, WB/EX-MEM feedback paths and the decode stage.
interface decode_stage_pipelined_if
  import decode_stage_pipelined_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA     = 5,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) ();

  // IF/ID side
  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  Instruction;
  logic [XLEN-1:0]     pc_plus4;
  logic [CTRL_W-1:0]   ctrl_in;

  // WB write port
  logic                wb_we;
  logic [RA-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;

  // EX/MEM forwarding source
  logic                exmem_we;
  logic [RA-1:0]       exmem_addr;
  logic [XLEN-1:0]     exmem_data;
  logic                exmem_is_load;

  // ID/EX side
  logic                out_valid;
  logic                out_ready;
  logic [CTRL_W-1:0]   out_ctrl;
  logic [XLEN-1:0]     out_rs_data;
  logic [XLEN-1:0]     out_rt_data;
  logic [XLEN-1:0]     out_imm;
  logic [RA-1:0]       out_rs;
  logic [RA-1:0]       out_rt;
  logic [RA-1:0]       out_rd;

  // Branch resolution and statistics
  logic                branch_taken;
  logic [XLEN-1:0]     branch_target;
  logic [CNT_W-1:0]    stall_count;

  // Environment around the decode stage
  modport master (
    output in_valid, Instruction, pc_plus4, ctrl_in,
           wb_we, wb_addr, wb_data,
           exmem_we, exmem_addr, exmem_data, exmem_is_load,
           out_ready,
    input  in_ready, out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm,
           out_rs, out_rt, out_rd, branch_taken, branch_target, stall_count
  );

  // Decode stage itself
  modport slave (
    input  in_valid, Instruction, pc_plus4, ctrl_in,
           wb_we, wb_addr, wb_data,
           exmem_we, exmem_addr, exmem_data, exmem_is_load,
           out_ready,
    output in_ready, out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm,
           out_rs, out_rt, out_rd, branch_taken, branch_target, stall_count
  );

endinterface

// File: rtl/decode_regfile.sv
// Register file with two read ports, one write port, r0 hardwired to zero
// and write-through so a same-cycle read of the WB address sees the new data.
module decode_regfile
  import decode_stage_pipelined_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA   = 5
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            wrEn,
  input  logic [RA-1:0]   wrAddr,
  input  logic [XLEN-1:0] wrData,
  input  logic [RA-1:0]   rdAddrA,
  output logic [XLEN-1:0] rdDataA,
  input  logic [RA-1:0]   rdAddrB,
  output logic [XLEN-1:0] rdDataB
);

  localparam int unsigned DEPTH = 1 << RA;

  logic [XLEN-1:0] mem [DEPTH];

  // Read with r0 forced to zero and write-through from the WB port
  function automatic logic [XLEN-1:0] readPort(
    input logic [RA-1:0]   addr,
    input logic [XLEN-1:0] stored,
    input logic            we,
    input logic [RA-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    if (addr == '0)             return '0;
    else if (we && (wa == addr)) return wd;
    else                        return stored;
  endfunction

  // Storage: cleared on reset, r0 never written
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn && (wrAddr != '0)) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Both read ports
  always_comb begin
    rdDataA = readPort(rdAddrA, mem[rdAddrA], wrEn, wrAddr, wrData);
    rdDataB = readPort(rdAddrB, mem[rdAddrB], wrEn, wrAddr, wrData);
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// ID stage: register read with EX/MEM and WB forwarding, hazard detection,
// branch resolution in ID and the ID/EX register behind a valid/ready handshake.
module decode_stage_pipelined
  import decode_stage_pipelined_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA     = 5,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  decode_stage_pipelined_if.slave bus
);

  // Instruction fields
  instrFields_t    iw;
  logic [5:0]      unusedOpcode;
  logic [RA-1:0]   rs;
  logic [RA-1:0]   rt;
  logic [RA-1:0]   rd;
  logic [15:0]     immRaw;

  assign iw           = bus.Instruction;
  assign unusedOpcode = iw.opcode;
  assign rs           = RA'(iw.rs);
  assign rt           = RA'(iw.rt);
  assign rd           = RA'(iw.rd);
  assign immRaw       = imm16(iw);

  // Decoded control bits of the incoming instruction
  logic isBranch;
  logic isBranchNe;
  logic lamux;
  logic usesRt;

  assign isBranch   = bus.ctrl_in[CTRL_BRANCH];
  assign isBranchNe = bus.ctrl_in[CTRL_BRANCH_NE];
  assign lamux      = bus.ctrl_in[CTRL_LAMUX];
  assign usesRt     = bus.ctrl_in[CTRL_USES_RT];

  // ID/EX register state
  logic              validQ;
  logic [CTRL_W-1:0] ctrlQ;
  logic [XLEN-1:0]   rsDataQ;
  logic [XLEN-1:0]   rtDataQ;
  logic [XLEN-1:0]   immQ;
  logic [RA-1:0]     rsQ;
  logic [RA-1:0]     rtQ;
  logic [RA-1:0]     rdQ;
  logic              branchTakenQ;
  logic [XLEN-1:0]   branchTargetQ;
  logic [CNT_W-1:0]  stallCountQ;

  // Register file
  logic [XLEN-1:0] rfRs;
  logic [XLEN-1:0] rfRt;

  decode_regfile #(
    .XLEN (XLEN),
    .RA   (RA)
  ) u_regfile (
    .Clock   (Clock),
    .Reset   (Reset),
    .wrEn    (bus.wb_we),
    .wrAddr  (bus.wb_addr),
    .wrData  (bus.wb_data),
    .rdAddrA (rs),
    .rdDataA (rfRs),
    .rdAddrB (rt),
    .rdDataB (rfRt)
  );

  // Operand priority: r0, then EX/MEM, then WB, then the register file
  function automatic logic [XLEN-1:0] pickOperand(
    input logic [RA-1:0]   addr,
    input logic [XLEN-1:0] rfVal,
    input logic            exWe,
    input logic [RA-1:0]   exAddr,
    input logic [XLEN-1:0] exData,
    input logic            wbWe,
    input logic [RA-1:0]   wbAddr,
    input logic [XLEN-1:0] wbData
  );
    if (addr == '0)                  return '0;
    else if (exWe && (exAddr == addr)) return exData;
    else if (wbWe && (wbAddr == addr)) return wbData;
    else                             return rfVal;
  endfunction

  logic [XLEN-1:0] rsVal;
  logic [XLEN-1:0] rtVal;
  logic [XLEN-1:0] immExt;
  logic [XLEN-1:0] target;

  // Forwarded operands, extended immediate and branch target
  always_comb begin
    rsVal  = pickOperand(rs, rfRs, bus.exmem_we, bus.exmem_addr, bus.exmem_data,
                         bus.wb_we, bus.wb_addr, bus.wb_data);
    rtVal  = pickOperand(rt, rfRt, bus.exmem_we, bus.exmem_addr, bus.exmem_data,
                         bus.wb_we, bus.wb_addr, bus.wb_data);
    immExt = lamux ? {{(XLEN-16){1'b0}}, immRaw} : {{(XLEN-16){immRaw[15]}}, immRaw};
    target = bus.pc_plus4 + (immExt << 2);
  end

  logic loadUse;
  logic branchEx;
  logic branchLoad;
  logic hazard;
  logic accept;
  logic takenNow;

  // Hazard detection; ID/EX does not carry RegDst, so rt and a nonzero rd are both treated as destinations
  always_comb begin
    loadUse    = validQ && ctrlQ[CTRL_MEM_READ] && (rtQ != '0) &&
                 ((rtQ == rs) || (usesRt && (rtQ == rt)));
    branchEx   = isBranch && validQ && ctrlQ[CTRL_REG_WRITE] &&
                 ((rtQ == rs) || (rtQ == rt) ||
                  ((rdQ != '0) && ((rdQ == rs) || (rdQ == rt))));
    branchLoad = isBranch && bus.exmem_is_load && (bus.exmem_addr != '0) &&
                 ((bus.exmem_addr == rs) || (bus.exmem_addr == rt));
    hazard     = bus.in_valid && (loadUse || branchEx || branchLoad);
    bus.in_ready = !hazard && (!validQ || bus.out_ready);
    accept     = bus.in_valid && bus.in_ready;
    takenNow   = (rsVal == rtVal) ^ isBranchNe;
  end

  // ID/EX register: load on accept, bubble when drained or stalled empty, else hold
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      validQ  <= 1'b0;
      ctrlQ   <= '0;
      rsDataQ <= '0;
      rtDataQ <= '0;
      immQ    <= '0;
      rsQ     <= '0;
      rtQ     <= '0;
      rdQ     <= '0;
    end else if (accept) begin
      validQ  <= 1'b1;
      ctrlQ   <= bus.ctrl_in;
      rsDataQ <= rsVal;
      rtDataQ <= rtVal;
      immQ    <= immExt;
      rsQ     <= rs;
      rtQ     <= rt;
      rdQ     <= rd;
    end else if (bus.out_ready || (hazard && !validQ)) begin
      validQ  <= 1'b0;
      ctrlQ   <= '0;
    end
  end

  // Branch resolution: one-cycle taken pulse, target captured with the branch
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      branchTakenQ  <= 1'b0;
      branchTargetQ <= '0;
    end else begin
      branchTakenQ <= accept && isBranch && takenNow;
      if (accept && isBranch) begin
        branchTargetQ <= target;
      end
    end
  end

  // Saturating count of cycles lost to hazards
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stallCountQ <= '0;
    end else if (hazard && (stallCountQ != '1)) begin
      stallCountQ <= stallCountQ + CNT_W'(1);
    end
  end

  assign bus.out_valid     = validQ;
  assign bus.out_ctrl      = ctrlQ;
  assign bus.out_rs_data   = rsDataQ;
  assign bus.out_rt_data   = rtDataQ;
  assign bus.out_imm       = immQ;
  assign bus.out_rs        = rsQ;
  assign bus.out_rt        = rtQ;
  assign bus.out_rd        = rdQ;
  assign bus.branch_taken  = branchTakenQ;
  assign bus.branch_target = branchTargetQ;
  assign bus.stall_count   = stallCountQ;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for the decode stage: directed scenarios plus random traffic checked
// against a behavioural model of the ID stage rules.
module tb_decode_stage_pipelined;
  import decode_stage_pipelined_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RA      = 5;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  always #5 Clock = ~Clock;

  decode_stage_pipelined_if #(.XLEN(XLEN), .RA(RA), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  decode_stage_pipelined #(.XLEN(XLEN), .RA(RA), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state: architectural registers and the ID/EX contents
  logic [XLEN-1:0]   regs [32];
  logic              mValid;
  logic [CTRL_W-1:0] mCtrl;
  logic [XLEN-1:0]   mRsData, mRtData, mImm, mTgt;
  logic [4:0]        mRs, mRt, mRd;
  logic              mBt;
  int unsigned       mCnt;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    mValid = 0; mCtrl = '0; mRsData = '0; mRtData = '0; mImm = '0; mTgt = '0;
    mRs = '0; mRt = '0; mRd = '0; mBt = 0; mCnt = 0;
  endtask

  function automatic logic [XLEN-1:0] operand(input logic [4:0] a);
    if (a == 0) return '0;
    if (bus.exmem_we && bus.exmem_addr == a) return bus.exmem_data;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return regs[a];
  endfunction

  task automatic setIdle();
    bus.in_valid = 0; bus.Instruction = '0; bus.pc_plus4 = '0; bus.ctrl_in = '0;
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.exmem_we = 0; bus.exmem_addr = '0; bus.exmem_data = '0; bus.exmem_is_load = 0;
    bus.out_ready = 1;
  endtask

  task automatic checkOutputs();
    checkEq("out_valid", 64'(bus.out_valid), 64'(mValid));
    checkEq("out_ctrl", 64'(bus.out_ctrl), 64'(mCtrl));
    checkEq("branch_taken", 64'(bus.branch_taken), 64'(mBt));
    checkEq("stall_count", 64'(bus.stall_count), 64'(mCnt));
    if (mValid) begin
      checkEq("out_rs_data", 64'(bus.out_rs_data), 64'(mRsData));
      checkEq("out_rt_data", 64'(bus.out_rt_data), 64'(mRtData));
      checkEq("out_imm", 64'(bus.out_imm), 64'(mImm));
      checkEq("out_rs", 64'(bus.out_rs), 64'(mRs));
      checkEq("out_rt", 64'(bus.out_rt), 64'(mRt));
      checkEq("out_rd", 64'(bus.out_rd), 64'(mRd));
    end
    if (mBt) checkEq("branch_target", 64'(bus.branch_target), 64'(mTgt));
  endtask

  // One clock: called just after a falling edge with inputs already driven
  task automatic doCycle();
    logic [31:0]       w;
    logic [CTRL_W-1:0] c;
    logic [4:0]        rs, rt, rd;
    logic [XLEN-1:0]   opRs, opRt, imm;
    logic              ld, brEx, brLd, hz, rdy, acc;
    w = bus.Instruction; c = bus.ctrl_in;
    rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
    opRs = operand(rs); opRt = operand(rt);
    imm = c[CTRL_LAMUX] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    ld   = mValid && mCtrl[CTRL_MEM_READ] && mRt != 0 &&
           (mRt == rs || (c[CTRL_USES_RT] && mRt == rt));
    brEx = c[CTRL_BRANCH] && mValid && mCtrl[CTRL_REG_WRITE] &&
           (mRt == rs || mRt == rt || (mRd != 0 && (mRd == rs || mRd == rt)));
    brLd = c[CTRL_BRANCH] && bus.exmem_is_load && bus.exmem_addr != 0 &&
           (bus.exmem_addr == rs || bus.exmem_addr == rt);
    hz   = bus.in_valid && (ld || brEx || brLd);
    rdy  = !hz && (!mValid || bus.out_ready);
    acc  = bus.in_valid && rdy;
    #1;
    checkEq("in_ready", 64'(bus.in_ready), 64'(rdy));
    @(posedge Clock);
    if (acc) begin
      mValid = 1; mCtrl = c; mRsData = opRs; mRtData = opRt; mImm = imm;
      mRs = rs; mRt = rt; mRd = rd;
    end else if (bus.out_ready || (hz && !mValid)) begin
      mValid = 0; mCtrl = '0;
    end
    mBt = acc && c[CTRL_BRANCH] && ((opRs == opRt) != c[CTRL_BRANCH_NE]);
    if (acc && c[CTRL_BRANCH]) mTgt = bus.pc_plus4 + imm * 4;
    if (hz && mCnt < CNT_MAX) mCnt++;
    if (bus.wb_we && bus.wb_addr != 0) regs[bus.wb_addr] = bus.wb_data;
    #1;
    checkOutputs();
    @(negedge Clock);
  endtask

  // Asynchronous reset from wherever the traffic currently is
  task automatic doReset();
    Reset = 0;
    #1;
    checkEq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkEq("rst_stall_count", 64'(bus.stall_count), 64'd0);
    checkEq("rst_branch_taken", 64'(bus.branch_taken), 64'd0);
    modelReset();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1;
    setIdle();
    #1;
    checkEq("rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  function automatic logic [31:0] rType(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {OP_RTYPE, s, t, d, 5'd0, FUNCT_ADD};
  endfunction

  localparam logic [CTRL_W-1:0] C_ALU = CTRL_W'((1 << CTRL_REG_WRITE) | (1 << CTRL_USES_RT));
  localparam logic [CTRL_W-1:0] C_LW  = CTRL_W'((1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_READ));
  localparam logic [CTRL_W-1:0] C_BEQ = CTRL_W'((1 << CTRL_BRANCH) | (1 << CTRL_USES_RT));

  initial begin
    logic [15:0] low;
    setIdle();
    modelReset();
    @(negedge Clock);
    doReset();

    // WB write-through into the same-cycle read
    bus.in_valid = 1; bus.Instruction = rType(5'd5, 5'd0, 5'd6); bus.ctrl_in = C_ALU;
    bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    doCycle();
    checkEq("wb_bypass_rs", 64'(bus.out_rs_data), 64'h1234);
    setIdle();
    doCycle();

    // Load-use bubble
    doReset();
    bus.in_valid = 1; bus.Instruction = {OP_LW, 5'd1, 5'd8, 16'd0}; bus.ctrl_in = C_LW;
    doCycle();
    bus.Instruction = rType(5'd8, 5'd8, 5'd9); bus.ctrl_in = C_ALU;
    doCycle();
    checkEq("lu_bubble_valid", 64'(bus.out_valid), 64'd0);
    checkEq("lu_stall_count", 64'(bus.stall_count), 64'd1);
    doCycle();
    checkEq("lu_issue_rd", 64'(bus.out_rd), 64'd9);
    checkEq("lu_issue_valid", 64'(bus.out_valid), 64'd1);

    // Forwarded beq: EX/MEM beats WB, one-cycle taken pulse
    doReset();
    bus.in_valid = 1; bus.Instruction = {OP_BEQ, 5'd3, 5'd3, 16'd5}; bus.ctrl_in = C_BEQ;
    bus.pc_plus4 = 32'h100;
    bus.exmem_we = 1; bus.exmem_addr = 5'd3; bus.exmem_data = 32'd7;
    bus.wb_we = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'd9;
    doCycle();
    checkEq("beq_rs_fwd", 64'(bus.out_rs_data), 64'd7);
    checkEq("beq_taken", 64'(bus.branch_taken), 64'd1);
    checkEq("beq_target", 64'(bus.branch_target), 64'h114);
    setIdle();
    doCycle();
    checkEq("beq_pulse_end", 64'(bus.branch_taken), 64'd0);
    // Reset while a taken pulse is pending
    bus.in_valid = 1; bus.Instruction = {OP_BNE, 5'd0, 5'd4, 16'hFFFF};
    bus.ctrl_in = C_BEQ | CTRL_W'(1 << CTRL_BRANCH_NE); bus.pc_plus4 = 32'h40;
    bus.wb_we = 1; bus.wb_addr = 5'd4; bus.wb_data = 32'd1;
    doCycle();
    checkEq("bne_taken", 64'(bus.branch_taken), 64'd1);
    checkEq("bne_target", 64'(bus.branch_target), 64'h3C);
    doReset();

    // EX back-pressure holds ID/EX
    bus.in_valid = 1; bus.Instruction = rType(5'd1, 5'd2, 5'd10); bus.ctrl_in = C_ALU;
    bus.out_ready = 0;
    doCycle();
    bus.Instruction = rType(5'd1, 5'd2, 5'd11);
    for (int i = 0; i < 3; i++) begin
      doCycle();
      checkEq("hold_rd", 64'(bus.out_rd), 64'd10);
      checkEq("hold_stall", 64'(bus.stall_count), 64'd0);
    end
    bus.out_ready = 1;
    doCycle();
    checkEq("resume_rd", 64'(bus.out_rd), 64'd11);

    // Saturating stall counter under a continuous load-use hazard
    doReset();
    bus.in_valid = 1; bus.Instruction = {OP_LW, 5'd1, 5'd8, 16'd4}; bus.ctrl_in = C_LW;
    doCycle();
    bus.out_ready = 0; bus.Instruction = rType(5'd8, 5'd8, 5'd9); bus.ctrl_in = C_ALU;
    for (int i = 0; i < int'(CNT_MAX) + 8; i++) doCycle();
    checkEq("stall_saturate", 64'(bus.stall_count), 64'(CNT_MAX));
    checkEq("sat_lw_held", 64'(bus.out_rt), 64'd8);
    doReset();

    // Random traffic on a small register window to provoke hazards and matches
    for (int n = 0; n < 2400; n++) begin
      if (n % 300 == 0) doReset();
      low = 16'($urandom);
      low[15:11] = 5'($urandom_range(0, 7));
      bus.in_valid = ($urandom_range(0, 9) < 8);
      bus.Instruction = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), low};
      bus.ctrl_in = (CTRL_W'($urandom) & ~CTRL_W'(1 << CTRL_BRANCH)) |
                    (($urandom_range(0, 3) == 0) ? CTRL_W'(1 << CTRL_BRANCH) : CTRL_W'(0));
      bus.pc_plus4 = $urandom;
      bus.wb_we = 1'($urandom); bus.wb_addr = 5'($urandom_range(0, 7)); bus.wb_data = $urandom;
      bus.exmem_we = 1'($urandom); bus.exmem_addr = 5'($urandom_range(0, 7));
      bus.exmem_data = $urandom; bus.exmem_is_load = ($urandom_range(0, 9) < 3);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      doCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
